cla_stream_accumulator: RTL

//  - Sequential accumulator that sits directly upstream of the 16-bit CLA adder path.
//  - Takes a stream of 16-bit operands over a valid/ready handshake and sums one packet of

---
 rtl/cla_stream_accumulator_pkg.sv | 13 +
 rtl/cla_16bit_comb.sv | 40 ++++
 rtl/cla_stream_accumulator.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cla_stream_accumulator_pkg.sv
// Shared constants for the CLA stream accumulator: default widths, the
// saturation ceiling of the counters and the FSM state encoding.
package cla_stream_accumulator_pkg;

    localparam int ACC_WIDTH   = 16;
    localparam int ACC_COUNT_W = 8;
    localparam int SAT_MAX     = (1 << ACC_COUNT_W) - 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/cla_16bit_comb.sv
// Purely combinational 16-bit carry-lookahead adder built from four 4-bit
// lookahead groups, with the group carry rippled from one group to the next.
module cla_16bit_comb (
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);

    logic [4:0] group_c;

    assign group_c[0] = c_in;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_group
            logic [3:0] g;
            logic [3:0] p;
            logic [3:0] c;

            assign g = in1[gi*4 +: 4] & in2[gi*4 +: 4];
            assign p = in1[gi*4 +: 4] ^ in2[gi*4 +: 4];

            // Every bit carry is expanded from the group carry-in, not rippled.
            assign c[0] = group_c[gi];
            assign c[1] = g[0] | (p[0] & group_c[gi]);
            assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & group_c[gi]);
            assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                        | (p[2] & p[1] & p[0] & group_c[gi]);
            assign group_c[gi+1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                                 | (p[3] & p[2] & p[1] & g[0])
                                 | (p[3] & p[2] & p[1] & p[0] & group_c[gi]);

            assign sum[gi*4 +: 4] = p ^ c;
        end
    endgenerate

    assign c_out = group_c[4];

endmodule

// File: rtl/cla_stream_accumulator.sv
// Sums one in_last-delimited packet of operands through a 16-bit CLA adder and
// holds the sum, a saturating carry-out count and a saturating beat count until accepted.
module cla_stream_accumulator
    import cla_stream_accumulator_pkg::*;
#(
    parameter int WIDTH   = ACC_WIDTH,
    parameter int COUNT_W = ACC_COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_sum,
    output logic [COUNT_W-1:0] out_carries,
    output logic [COUNT_W-1:0] out_beats
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic [1:0]         state_q,   state_d;
    logic [WIDTH-1:0]   acc_q,     acc_d;
    logic [COUNT_W-1:0] carries_q, carries_d;
    logic [COUNT_W-1:0] beats_q,   beats_d;
    logic               live_q;

    logic [15:0]        add_sum;
    logic               add_cout;
    logic               beat_fire;
    logic [COUNT_W-1:0] carries_inc;
    logic [COUNT_W-1:0] beats_inc;

    cla_16bit_comb u_adder (
        .in1   (acc_q),
        .in2   (in_data),
        .c_in  (1'b0),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    // live_q holds in_ready low until the first clock edge after reset release.
    assign in_ready  = live_q && (state_q != ST_DONE) && !clear;
    assign beat_fire = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);

    assign out_sum     = out_valid ? acc_q     : '0;
    assign out_carries = out_valid ? carries_q : '0;
    assign out_beats   = out_valid ? beats_q   : '0;

    assign carries_inc = (carries_q == CNT_MAX) ? carries_q
                                                : carries_q + COUNT_W'(add_cout);
    assign beats_inc   = (beats_q == CNT_MAX) ? beats_q : beats_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        carries_d = carries_q;
        beats_d   = beats_q;

        if (clear) begin
            state_d   = ST_IDLE;
            acc_d     = '0;
            carries_d = '0;
            beats_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (beat_fire) begin
                        acc_d     = in_data;
                        carries_d = '0;
                        beats_d   = COUNT_W'(1);
                        state_d   = in_last ? ST_DONE : ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (beat_fire) begin
                        acc_d     = add_sum;
                        carries_d = carries_inc;
                        beats_d   = beats_inc;
                        state_d   = in_last ? ST_DONE : ST_ACC;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d   = ST_IDLE;
                        acc_d     = '0;
                        carries_d = '0;
                        beats_d   = '0;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    acc_d     = '0;
                    carries_d = '0;
                    beats_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            carries_q <= '0;
            beats_q   <= '0;
            live_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            carries_q <= carries_d;
            beats_q   <= beats_d;
            live_q    <= 1'b1;
        end
    end

endmodule
